mem_bus_decoder: RTL and testbench
==================================

Name: mem_bus_decoder

Overview:
Sits between the picorv32 native memory port and the on-chip slaves: the BRAM wrapper (ram_*) and the peripheral bus (per_*). It decodes each CPU request to one region, forwards it with latched address, data and strobes, and returns a registered one-cycle ready. It inserts a turnaround cycle so stale slave ready pulses never leak into the next access, and it terminates unmapped or hung accesses with an error word and a sticky error flag.

Parameters:
RAM_BASE, 32'h0000_0000, RAM region base; aligned to 2**RAM_AW
RAM_AW, 12, RAM region size log2 in bytes (4 KiB)
PER_BASE, 32'h0200_0000, peripheral region base; aligned to 2**PER_AW
PER_AW, 16, peripheral region size log2 in bytes
TIMEOUT, 16, max cycles in ACCESS before forced error completion (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error completion

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
mem_valid  in  1  CPU request; held until mem_ready
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables; 0 = read
mem_rdata  out  32  read data, valid while mem_ready=1
ram_valid / per_valid  out  1  slave request
ram_ready / per_ready  in  1  slave completion
ram_addr / per_addr  out  32  latched mem_addr
ram_wdata / per_wdata  out  32  latched mem_wdata
ram_wstrb / per_wstrb  out  4  latched mem_wstrb
ram_rdata / per_rdata  in  32  slave read data
bus_err  out  1  sticky error flag
err_addr  out  32  address of first error since clear
err_clr  in  1  synchronous clear of bus_err/err_addr

Behaviour:
- States IDLE, ACCESS, ERROR, TURN. Reset: IDLE; all outputs 0; latched addr/wdata/wstrb 0.
- Decode: hit_ram = (mem_addr>>RAM_AW)==(RAM_BASE>>RAM_AW); hit_per likewise. RAM wins on overlap.
- IDLE: if mem_valid, latch addr/wdata/wstrb and sel. On a hit go to ACCESS, otherwise go to ERROR.
- ACCESS: the selected slave valid=1; the other slave valid=0. Slave addr/wdata/wstrb are shared latched values. The timeout counter starts at 0 and increments each cycle.
  - Selected ready=1: capture its rdata into mem_rdata, set mem_ready=1 (registered), go to TURN.
  - Counter==TIMEOUT-1 with no ready: error completion.
- ERROR (unmapped, 1 cycle): error completion.
- Error completion: mem_rdata<=ERR_DATA; mem_ready<=1; go to TURN. If bus_err=0: bus_err<=1 and err_addr<=latched addr. Later errors do not overwrite err_addr. Unmapped writes are dropped.
- TURN (1 cycle): mem_ready=1 and all slave valids=0; mem_valid is ignored; next state IDLE. mem_ready and mem_rdata are 0 in every other state.
- Latency:
  - RAM read/write: mem_valid sampled in cycle 0, ram_valid in cycles 1-2, mem_ready in cycle 3. Back-to-back: next mem_valid is accepted in cycle 4.
  - Unmapped: mem_ready in cycle 2.
  - Timeout: mem_ready in cycle TIMEOUT+1.
- Slave ready outside ACCESS, or from the unselected slave, is ignored.
- err_clr clears bus_err and err_addr. If err_clr coincides with an error completion, the new error wins (bus_err=1, err_addr=new).
- Reset mid-access: immediate return to IDLE, all valids/ready 0; no completion is issued.

Test Plan:
1. Write 32'h1234_5678, wstrb 4'hF, to 0x0000_0010, then read the same address. -> Each mem_ready comes 3 cycles after mem_valid. ram_valid is high for exactly 2 cycles with ram_addr=0x10. Read returns 32'h1234_5678.
2. Back-to-back reads to 0x0 and 0x4 with mem_valid held continuously. -> Exactly two mem_ready pulses. ram_valid is low during TURN. No stale ram_ready produces an extra completion.
3. Read 0x0200_0008 with per_ready asserted 5 cycles after per_valid rises, per_rdata=0xA5. -> per_valid high for 5 cycles, mem_rdata=0xA5, ram_valid stays 0.
4. Read 0x1000_0000 (unmapped). -> mem_ready in cycle 2, mem_rdata=32'hDEAD_BEEF, bus_err=1, err_addr=0x1000_0000. No slave valid ever rises.
5. Peripheral read with per_ready tied 0, then an unmapped access, then err_clr. -> Timeout completion at cycle 17 with ERR_DATA and err_addr=0x0200_xxxx. The unmapped access leaves err_addr unchanged. err_clr zeroes bus_err and err_addr.
6. resetn pulsed low in cycle 1 of a RAM access. -> ram_valid and mem_ready drop immediately. After release the FSM is in IDLE and a fresh read completes normally.

Source files
------------

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: routes picorv32 native memory requests to the BRAM wrapper
// or the peripheral bus. It latches the request, waits for the selected slave,
// returns a registered one-cycle ready, and inserts a turnaround cycle so that
// late slave ready pulses cannot complete the next access. Unmapped or hung
// accesses finish with an error word and set a sticky error flag.
module mem_bus_decoder #(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int          RAM_AW   = 12,
  parameter logic [31:0] PER_BASE = 32'h0200_0000,
  parameter int          PER_AW   = 16,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  // CPU side
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  // BRAM wrapper
  output logic        ram_valid,
  input  logic        ram_ready,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  // Peripheral bus
  output logic        per_valid,
  input  logic        per_ready,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic [31:0] per_rdata,
  // Error reporting
  output logic        bus_err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  // TIMEOUT >= 2, so the counter is at least one bit wide and holds TIMEOUT-1.
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERROR,
    TURN
  } state_t;

  state_t            state_q,     state_d;
  logic              sel_ram_q,   sel_ram_d;
  logic [31:0]       addr_q,      addr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [3:0]        wstrb_q,     wstrb_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              ram_valid_q, ram_valid_d;
  logic              per_valid_q, per_valid_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              bus_err_q,   bus_err_d;
  logic [31:0]       err_addr_q,  err_addr_d;

  logic              hit_ram;
  logic              hit_per;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              err_done;

  // RAM takes priority if the two windows ever overlap.
  assign hit_ram   = (mem_addr >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign hit_per   = (mem_addr >> PER_AW) == (PER_BASE >> PER_AW);
  assign sel_ready = sel_ram_q ? ram_ready : per_ready;
  assign sel_rdata = sel_ram_q ? ram_rdata : per_rdata;

  // Next-state, request latching, completion and sticky error logic.
  always_comb begin
    state_d     = state_q;
    sel_ram_d   = sel_ram_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    ram_valid_d = 1'b0;
    per_valid_d = 1'b0;
    mem_ready_d = 1'b0;
    mem_rdata_d = 32'h0;
    bus_err_d   = bus_err_q;
    err_addr_d  = err_addr_q;
    err_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          sel_ram_d = hit_ram;
          if (hit_ram || hit_per) begin
            state_d     = ACCESS;
            cnt_d       = '0;
            ram_valid_d = hit_ram;
            per_valid_d = !hit_ram;
          end else begin
            state_d = ERROR;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          mem_ready_d = 1'b1;
          mem_rdata_d = sel_rdata;
          state_d     = TURN;
        end else if (cnt_q == CNT_LAST) begin
          err_done = 1'b1;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          ram_valid_d = ram_valid_q;
          per_valid_d = per_valid_q;
        end
      end
      ERROR: begin
        err_done = 1'b1;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_clr) begin
      bus_err_d  = 1'b0;
      err_addr_d = 32'h0;
    end

    // A clear in the same cycle as a new error still records the new error.
    if (err_done) begin
      mem_ready_d = 1'b1;
      mem_rdata_d = ERR_DATA;
      state_d     = TURN;
      if (!bus_err_q || err_clr) begin
        bus_err_d  = 1'b1;
        err_addr_d = addr_q;
      end
    end
  end

  // State and registered outputs; reset drops every output immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_ram_q   <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      cnt_q       <= '0;
      ram_valid_q <= 1'b0;
      per_valid_q <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      sel_ram_q   <= sel_ram_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      ram_valid_q <= ram_valid_d;
      per_valid_q <= per_valid_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_valid = ram_valid_q;
  assign per_valid = per_valid_q;
  assign ram_addr  = addr_q;
  assign per_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign per_wdata = wdata_q;
  assign ram_wstrb = wstrb_q;
  assign per_wstrb = wstrb_q;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: table-driven, directed and randomized checks of
// mem_bus_decoder against a transaction-level reference model.
module tb_mem_bus_decoder;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        ram_valid;
  logic        ram_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;
  logic        per_valid;
  logic        per_ready;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_wstrb;
  logic [31:0] per_rdata;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  mem_bus_decoder #(
    .RAM_BASE(32'h0000_0000), .RAM_AW(12),
    .PER_BASE(32'h0200_0000), .PER_AW(16),
    .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
    .per_valid(per_valid), .per_ready(per_ready), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_wstrb(per_wstrb), .per_rdata(per_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM slave: ready follows valid by one cycle and is never self-cleared,
  // so a stale ready pulse appears in the cycle after every access.
  logic [31:0] bram [0:1023];
  logic        ram_ready_q;
  logic [31:0] ram_rdata_q;
  logic        ram_stray;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_ready_q <= 1'b0;
      ram_rdata_q <= 32'h0;
      for (int w = 0; w < 1024; w++) bram[w] <= 32'h0;
    end else begin
      ram_ready_q <= ram_valid;
      if (ram_valid) begin
        ram_rdata_q <= bram[ram_addr[11:2]];
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) bram[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end
  assign ram_ready = ram_ready_q || ram_stray;
  assign ram_rdata = ram_rdata_q;

  // Peripheral slave: answers in the per_delay-th cycle of per_valid (0 = never).
  int          per_cnt;
  int          per_delay;
  logic [31:0] per_data;
  logic        per_stray;
  always @(posedge clk) begin
    if (!per_valid) per_cnt <= 0;
    else            per_cnt <= per_cnt + 1;
  end
  assign per_ready = (per_valid && per_delay > 0 && per_cnt == per_delay - 1) || per_stray;
  assign per_rdata = per_ready ? per_data : 32'h0;

  typedef struct {
    int          lat;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          ramv;
    int          perv;
    logic        bus_err;
    logic [31:0] err_addr;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          ramv;
    int          perv;
    logic        fwd_bad;
    logic        leak;
    logic        bus_err;
    logic [31:0] err_addr;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          pdelay;
    logic [31:0] pdata;
    exp_t        e;
  } vec_t;

  // Reference model state: memory contents and the sticky error record.
  logic [31:0] ref_mem [0:1023];
  logic        ref_bus_err;
  logic [31:0] ref_err_addr;

  task automatic resetModel();
    for (int w = 0; w < 1024; w++) ref_mem[w] = 32'h0;
    ref_bus_err  = 1'b0;
    ref_err_addr = 32'h0;
  endtask

  // Transaction-level prediction from the region map and latency rules.
  task automatic refModel(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int pdelay,
                          input logic [31:0] pdata, input int clr_cycle,
                          output exp_t e);
    logic is_err;
    logic [31:0] word;
    is_err      = 1'b0;
    e.ramv      = 0;
    e.perv      = 0;
    e.chk_rdata = 1'b1;
    e.rdata     = 32'h0;
    if (addr < 32'h0000_1000) begin
      e.lat  = 3;
      e.ramv = 2;
      word   = ref_mem[addr[11:2]];
      if (wstrb == 4'h0) begin
        e.rdata = word;
      end else begin
        e.chk_rdata = 1'b0;
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[addr[11:2]] = word;
      end
    end else if (addr >= 32'h0200_0000 && addr < 32'h0201_0000) begin
      if (pdelay >= 1 && pdelay <= TIMEOUT) begin
        e.lat   = pdelay + 1;
        e.perv  = pdelay;
        e.rdata = pdata;
      end else begin
        e.lat   = TIMEOUT + 1;
        e.perv  = TIMEOUT;
        e.rdata = ERR_DATA;
        is_err  = 1'b1;
      end
    end else begin
      e.lat   = 2;
      e.rdata = ERR_DATA;
      is_err  = 1'b1;
    end
    if (clr_cycle >= 0 && clr_cycle < e.lat) begin
      ref_bus_err  = 1'b0;
      ref_err_addr = 32'h0;
    end
    if (is_err && !ref_bus_err) begin
      ref_bus_err  = 1'b1;
      ref_err_addr = addr;
    end
    e.bus_err  = ref_bus_err;
    e.err_addr = ref_err_addr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at the start of a cycle; drives one request and observes it until
  // mem_ready or the cycle bound, returning at the start of the next cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int pdelay,
                               input logic [31:0] pdata, input int clr_cycle,
                               output obs_t o);
    o.lat = -1; o.rdata = 32'h0; o.ramv = 0; o.perv = 0;
    o.fwd_bad = 1'b0; o.leak = 1'b0; o.bus_err = 1'b0; o.err_addr = 32'h0;
    per_delay = pdelay;
    per_data  = pdata;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      err_clr = (c == clr_cycle);
      @(negedge clk);
      if (ram_valid) begin
        o.ramv++;
        if (ram_addr !== addr || ram_wdata !== wdata || ram_wstrb !== wstrb) o.fwd_bad = 1'b1;
      end
      if (per_valid) begin
        o.perv++;
        if (per_addr !== addr || per_wdata !== wdata || per_wstrb !== wstrb) o.fwd_bad = 1'b1;
      end
      if (mem_ready) begin
        o.lat      = c;
        o.rdata    = mem_rdata;
        o.bus_err  = bus_err;
        o.err_addr = err_addr;
      end else if (mem_rdata !== 32'h0) begin
        o.leak = 1'b1;
      end
      @(posedge clk);
      #1;
      if (o.lat >= 0) break;
    end
    err_clr   = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic checkTxn(input string name, input exp_t e, input obs_t o);
    checkOutput({name, ".latency"}, o.lat, e.lat);
    if (e.chk_rdata) checkOutput({name, ".rdata"}, o.rdata, e.rdata);
    checkOutput({name, ".ram_valid_cycles"}, o.ramv, e.ramv);
    checkOutput({name, ".per_valid_cycles"}, o.perv, e.perv);
    checkOutput({name, ".forwarding"}, {31'h0, o.fwd_bad}, 32'h0);
    checkOutput({name, ".rdata_idle_zero"}, {31'h0, o.leak}, 32'h0);
    checkOutput({name, ".bus_err"}, {31'h0, o.bus_err}, {31'h0, e.bus_err});
    checkOutput({name, ".err_addr"}, o.err_addr, e.err_addr);
  endtask

  task automatic runTxn(input string name, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int pdelay, input logic [31:0] pdata,
                        input int clr_cycle, output obs_t o);
    exp_t e;
    refModel(addr, wdata, wstrb, pdelay, pdata, clr_cycle, e);
    applyStimulus(addr, wdata, wstrb, pdelay, pdata, clr_cycle, o);
    checkTxn(name, e, o);
  endtask

  vec_t vecs [7];
  obs_t o;
  exp_t e;
  int   pulses;

  initial begin
    // Expected values written out by hand from the latency/decode rules.
    vecs[0] = '{32'h0000_0010, 32'h1234_5678, 4'hF, 0, 32'h0, '{3, 1'b0, 32'h0,          2, 0, 1'b0, 32'h0}};
    vecs[1] = '{32'h0000_0010, 32'h0,         4'h0, 0, 32'h0, '{3, 1'b1, 32'h1234_5678,  2, 0, 1'b0, 32'h0}};
    vecs[2] = '{32'h0000_0004, 32'hCAFE_F00D, 4'h3, 0, 32'h0, '{3, 1'b0, 32'h0,          2, 0, 1'b0, 32'h0}};
    vecs[3] = '{32'h0000_0000, 32'h0,         4'h0, 0, 32'h0, '{3, 1'b1, 32'h0,          2, 0, 1'b0, 32'h0}};
    vecs[4] = '{32'h0000_0004, 32'h0,         4'h0, 0, 32'h0, '{3, 1'b1, 32'h0000_F00D,  2, 0, 1'b0, 32'h0}};
    vecs[5] = '{32'h0200_0008, 32'h0,         4'h0, 5, 32'hA5,'{6, 1'b1, 32'h0000_00A5,  0, 5, 1'b0, 32'h0}};
    vecs[6] = '{32'h1000_0000, 32'h5555_AAAA, 4'hF, 0, 32'h0, '{2, 1'b1, 32'hDEAD_BEEF,  0, 0, 1'b1, 32'h1000_0000}};

    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_wstrb = 4'h0; err_clr = 1'b0; per_delay = 0; per_data = 32'h0;
    ram_stray = 1'b0; per_stray = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.mem_ready", {31'h0, mem_ready}, 32'h0);
    checkOutput("reset.mem_rdata", mem_rdata, 32'h0);
    checkOutput("reset.ram_valid", {31'h0, ram_valid}, 32'h0);
    checkOutput("reset.per_valid", {31'h0, per_valid}, 32'h0);
    checkOutput("reset.bus_err", {31'h0, bus_err}, 32'h0);
    checkOutput("reset.err_addr", err_addr, 32'h0);
    checkOutput("reset.ram_addr", ram_addr, 32'h0);
    checkOutput("reset.per_wstrb", {28'h0, per_wstrb}, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table: RAM write/read, back-to-back reads, slow peripheral, unmapped.
    for (int i = 0; i < 7; i++) begin
      refModel(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].pdelay, vecs[i].pdata, -1, e);
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].pdelay, vecs[i].pdata, -1, o);
      checkTxn($sformatf("vec%0d", i), vecs[i].e, o);
    end

    // Stray slave ready pulses while idle must not produce completions.
    pulses = 0;
    ram_stray = 1'b1; per_stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    ram_stray = 1'b0; per_stray = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_stray.pulses", pulses, 0);

    // Standalone clear of the error record.
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    ref_bus_err = 1'b0; ref_err_addr = 32'h0;
    checkOutput("clear.bus_err", {31'h0, bus_err}, 32'h0);
    checkOutput("clear.err_addr", err_addr, 32'h0);

    // Hung peripheral, then an unmapped access that must not overwrite err_addr.
    runTxn("timeout", 32'h0200_0040, 32'h0, 4'h0, 0, 32'h0, -1, o);
    checkOutput("timeout.cycle", o.lat, TIMEOUT + 1);
    checkOutput("timeout.err_addr_const", o.err_addr, 32'h0200_0040);
    runTxn("second_err", 32'h3000_0000, 32'h0, 4'h0, 0, 32'h0, -1, o);
    checkOutput("second_err.err_addr_kept", o.err_addr, 32'h0200_0040);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    ref_bus_err = 1'b0; ref_err_addr = 32'h0;
    checkOutput("clear2.bus_err", {31'h0, bus_err}, 32'h0);
    checkOutput("clear2.err_addr", err_addr, 32'h0);

    // Clear coinciding with a new error completion: the new error wins.
    runTxn("pre_err", 32'h1000_0000, 32'h0, 4'h0, 0, 32'h0, -1, o);
    runTxn("clr_coincide", 32'h2000_0000, 32'h0, 4'h0, 0, 32'h0, 1, o);
    checkOutput("clr_coincide.err_addr_const", o.err_addr, 32'h2000_0000);

    // Unselected slave ready during a peripheral access is ignored.
    ram_stray = 1'b1;
    runTxn("unsel_ready", 32'h0200_1234, 32'h0, 4'h0, 3, 32'h0BAD_F00D, -1, o);
    ram_stray = 1'b0;

    // Reset in cycle 1 of a RAM access.
    mem_addr = 32'h0000_0020; mem_wdata = 32'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid.ram_valid_before", {31'h0, ram_valid}, 32'h1);
    resetn = 1'b0;
    #1;
    checkOutput("rst_mid.ram_valid", {31'h0, ram_valid}, 32'h0);
    checkOutput("rst_mid.mem_ready", {31'h0, mem_ready}, 32'h0);
    mem_valid = 1'b0;
    resetModel();
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_ready || ram_valid) pulses++;
    end
    checkOutput("rst_mid.no_completion", pulses, 0);
    @(posedge clk);
    #1;
    runTxn("rst_mid.write", 32'h0000_0020, 32'h0F0F_1234, 4'hF, 0, 32'h0, -1, o);
    runTxn("rst_mid.read", 32'h0000_0020, 32'h0, 4'h0, 0, 32'h0, -1, o);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int          region;
      region = $urandom_range(0, 2);
      if (region == 0)      a = 32'($urandom_range(0, 1023)) << 2;
      else if (region == 1) a = 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
      else                  a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      ram_stray = (region != 0) && ($urandom_range(0, 1) == 1);
      per_stray = (region == 0) && ($urandom_range(0, 1) == 1);
      runTxn($sformatf("rand%0d", n), a, $urandom, s, $urandom_range(0, TIMEOUT + 1),
             $urandom, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : -1, o);
      ram_stray = 1'b0;
      per_stray = 1'b0;
    end

    @(negedge clk);
    checkOutput("final.single_pulse", {31'h0, mem_ready}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
